ysyx_24080006_wbu_q: RTL and testbench
======================================

// Module: ysyx_24080006_wbu_q
// PURPOSE
//  Parametrised writeback unit with completion queue: accepts finished instructions from LSU over valid/ready,
//  selects and formats writeback data (ALU/MEM/CSR/PC+4, sub-word load extension), buffers DEPTH entries,
//  retires in order to IFU over valid/ready and drives the register-file write port one write per retired instruction.
// PARAMETERS
//  XLEN    32  datapath width
//  REG_AW  4   register address width (RV32E: 16 regs)
//  DEPTH   2   completion-queue entries, power of two, >=2
// PORTS
//  clock         in   1       system clock
//  reset         in   1       synchronous, active-high reset
//  lsu_valid     in   1       LSU has a completed instruction
//  lsu_ready     out  1       queue can accept
//  alu_result    in   XLEN    ALU result
//  mem_rdata     in   XLEN    raw aligned memory word
//  csr_rdata     in   XLEN    CSR read value
//  pc            in   XLEN    instruction PC (PC+4 source)
//  wb_sel        in   4       one-hot {pc4,csr,mem,alu}; 0 = no write
//  ld_fmt        in   3       funct3 of load: LB/LH/LW/LBU/LHU
//  addr_lo       in   2       load address [1:0], byte lane select
//  rd            in   REG_AW  destination register
//  ifu_valid     out  1       instruction retired, IFU may fetch
//  ifu_ready     in   1       IFU accepts retire
//  rd_data       out  XLEN    regfile write data
//  rd_addr       out  REG_AW  regfile write address
//  rd_we         out  1       regfile write enable, one-cycle pulse
// BEHAVIOUR
//  - Reset: queue empty, lsu_ready=0 during reset then 1, ifu_valid=0, rd_data=0, rd_addr=0, rd_we=0. Reset mid-operation drops all entries, no write issued.
//  - Enqueue on lsu_valid&&lsu_ready; data selected/formatted at enqueue, stored as {data, rd, we}.
//  - we = (wb_sel!=0) && (rd!=0). wb_sel not one-hot is illegal (assertion); RTL uses lowest set bit.
//  - pc4 = pc + 4, modulo 2^XLEN (wraps, no carry out).
//  - Load format: byte lane addr_lo, half lane addr_lo[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes word.
//    Misaligned half (addr_lo[0]=1) uses lane addr_lo[1]; no trap raised here.
//  - Queue occupancy: EMPTY (cnt=0), PARTIAL, FULL (cnt=DEPTH); pointers wrap modulo DEPTH.
//  - lsu_ready = !FULL || (ifu_valid&&ifu_ready): push into full queue allowed in same cycle as pop.
//  - ifu_valid = !EMPTY (head valid). Retire on ifu_valid&&ifu_ready; in-order, exactly once.
//  - Simultaneous push+pop: cnt unchanged, both pointers advance.
//  - rd_we/rd_data/rd_addr registered: cycle after retire, rd_we=entry.we, rd_data/rd_addr=entry fields;
//    when not retiring next cycle rd_we=0, rd_data=0, rd_addr=0.
//  - Latency: enqueue cycle N -> ifu_valid at N+1 -> rd_we at N+2 (if retired at N+1).
//  - ifu_valid holds with stable head until ifu_ready (no drop, no reorder).
// CONFIGURATION
//  YSYX_24080006_WBU_BYPASS_EN defined: when queue EMPTY and lsu_valid, ifu_valid asserts same cycle
//   (combinational pass-through); if ifu_ready, entry retires without enqueue, rd_we at N+1.
//  Undefined: all entries pass through queue; minimum enqueue->ifu_valid latency 1 cycle.
//  Ordering, one-write-per-retire and reset rules identical in both builds.
// STRUCTURE
//  Package ysyx_24080006_pkg: wb_sel bit indices (WB_ALU=0,WB_MEM,WB_CSR,WB_PC4), ld_fmt_e enum
//   (LB=3'b000,LH=3'b001,LW=3'b010,LBU=3'b100,LHU=3'b101), wb_entry_t struct {data,rd,we}.
//  Sub-module ysyx_24080006_ld_fmt: combinational load extraction/extension (mem_rdata, addr_lo, ld_fmt -> XLEN).
//  Queue storage, pointers, count and rd_* registers live in this module.
// TESTING
//  1 ALU: wb_sel=0001, alu_result=0x1234_5678, rd=5, ifu_ready=1 -> ifu_valid N+1, rd_we=1 rd_addr=5 rd_data=0x12345678 at N+2.
//  2 Loads: mem_rdata=0x80FF_7F01; LB addr_lo=1 -> 0x0000_007F; LB addr_lo=2 -> 0xFFFF_FFFF; LHU addr_lo=2 -> 0x0000_80FF; LH addr_lo=2 -> 0xFFFF_80FF.
//  3 rd=0 or wb_sel=0 with alu_result=0xDEAD_BEEF -> ifu_valid handshake occurs, rd_we stays 0.
//  4 Backpressure: ifu_ready=0, push 3 -> lsu_ready=0 after 2 (DEPTH=2); ifu_ready=1 with lsu_valid -> push+pop same cycle, retire order 1,2,3.
//  5 PC+4: pc=0xFFFF_FFFC, wb_sel=1000 -> rd_data=0x0000_0000; pc=0x8000_0000 -> 0x8000_0004.
//  6 Reset with 2 entries queued -> next cycle ifu_valid=0, rd_we=0, no retire of dropped entries; bypass build: ifu_valid same cycle as lsu_valid when empty.

Source files
------------

// File: rtl/ysyx_24080006_pkg.sv
// rtl/ysyx_24080006_pkg.sv - shared writeback-unit constants, load formats and entry layout
package ysyx_24080006_pkg;

   // Bit positions inside the one-hot wb_sel vector
   localparam int WB_ALU = 0;
   localparam int WB_MEM = 1;
   localparam int WB_CSR = 2;
   localparam int WB_PC4 = 3;

   // Load funct3 encodings
   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } ld_fmt_e;

   // Completion entry layout for the default RV32E configuration
   localparam int WB_XLEN   = 32;
   localparam int WB_REG_AW = 4;

   typedef struct packed {
      logic [WB_XLEN-1:0]   data;
      logic [WB_REG_AW-1:0] rd;
      logic                 we;
   } wb_entry_t;

   // Isolate the lowest set bit so a malformed select still picks one source
   function automatic logic [3:0] wb_sel_lowest(input logic [3:0] sel);
      return sel & (~sel + 4'd1);
   endfunction

endpackage

// File: rtl/ysyx_24080006_ld_fmt.sv
// rtl/ysyx_24080006_ld_fmt.sv - load lane extraction and sign/zero extension
module ysyx_24080006_ld_fmt
   import ysyx_24080006_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] mem_rdata,
   input  logic [1:0]      addr_lo,
   input  logic [2:0]      ld_fmt,
   output logic [XLEN-1:0] ld_data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Pick the addressed byte/half lane, then extend according to funct3
   always_comb begin
      byte_v  = 8'h00;
      half_v  = 16'h0000;
      ld_data = mem_rdata;
      case (addr_lo)
         2'd0:    byte_v = mem_rdata[7:0];
         2'd1:    byte_v = mem_rdata[15:8];
         2'd2:    byte_v = mem_rdata[23:16];
         default: byte_v = mem_rdata[31:24];
      endcase
      // A misaligned half simply uses the half lane selected by addr_lo[1]
      half_v = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (ld_fmt)
         LB:      ld_data = {{(XLEN-8){byte_v[7]}}, byte_v};
         LH:      ld_data = {{(XLEN-16){half_v[15]}}, half_v};
         LBU:     ld_data = {{(XLEN-8){1'b0}}, byte_v};
         LHU:     ld_data = {{(XLEN-16){1'b0}}, half_v};
         default: ld_data = mem_rdata;
      endcase
   end

endmodule

// File: rtl/ysyx_24080006_wbu_q.sv
// rtl/ysyx_24080006_wbu_q.sv - writeback unit with in-order completion queue (option: YSYX_24080006_WBU_BYPASS_EN)
module ysyx_24080006_wbu_q
   import ysyx_24080006_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 4,
   parameter int DEPTH  = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic [XLEN-1:0]   alu_result,
   input  logic [XLEN-1:0]   mem_rdata,
   input  logic [XLEN-1:0]   csr_rdata,
   input  logic [XLEN-1:0]   pc,
   input  logic [3:0]        wb_sel,
   input  logic [2:0]        ld_fmt,
   input  logic [1:0]        addr_lo,
   input  logic [REG_AW-1:0] rd,
   output logic              ifu_valid,
   input  logic              ifu_ready,
   output logic [XLEN-1:0]   rd_data,
   output logic [REG_AW-1:0] rd_addr,
   output logic              rd_we
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [XLEN-1:0]   data;
      logic [REG_AW-1:0] rd;
      logic              we;
   } q_entry_t;

   q_entry_t        q_mem [DEPTH];
   logic [AW-1:0]   head_ptr;
   logic [AW-1:0]   tail_ptr;
   logic [AW:0]     cnt;
   logic            q_empty;
   logic            q_full;
   logic            bypass;
   logic            retire;
   logic            push;
   logic            pop;
   logic [3:0]      sel;
   logic [XLEN-1:0] ld_data;
   q_entry_t        in_entry;
   q_entry_t        head_entry;

   ysyx_24080006_ld_fmt #(.XLEN(XLEN)) u_ld_fmt (
      .mem_rdata (mem_rdata),
      .addr_lo   (addr_lo),
      .ld_fmt    (ld_fmt),
      .ld_data   (ld_data)
   );

   // Format the incoming instruction's writeback entry at enqueue time
   always_comb begin
      sel           = wb_sel_lowest(wb_sel);
      in_entry.data = '0;
      if (sel[WB_ALU])      in_entry.data = alu_result;
      else if (sel[WB_MEM]) in_entry.data = ld_data;
      else if (sel[WB_CSR]) in_entry.data = csr_rdata;
      else if (sel[WB_PC4]) in_entry.data = pc + XLEN'(4);
      in_entry.rd = rd;
      in_entry.we = (wb_sel != 4'd0) && (rd != '0);
   end

   assign q_empty = (cnt == '0);
   assign q_full  = (cnt == (AW+1)'(DEPTH));

`ifdef YSYX_24080006_WBU_BYPASS_EN
   assign bypass = q_empty && lsu_valid;
`else
   assign bypass = 1'b0;
`endif

   // With an empty queue the only possible head is the bypassed instruction
   assign head_entry = q_empty ? in_entry : q_mem[head_ptr];
   assign ifu_valid  = !reset && (!q_empty || bypass);
   assign retire     = ifu_valid && ifu_ready;
   assign lsu_ready  = !reset && (!q_full || retire);
   assign push       = lsu_valid && lsu_ready && !(bypass && retire);
   assign pop        = retire && !q_empty;

   // Queue pointers and occupancy; reset drops every buffered entry
   always_ff @(posedge clock) begin
      if (reset) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         cnt      <= '0;
      end else begin
         if (push) tail_ptr <= tail_ptr + AW'(1);
         if (pop)  head_ptr <= head_ptr + AW'(1);
         cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   // Entry storage needs no reset: occupancy alone decides what is valid
   always_ff @(posedge clock) begin
      if (push) q_mem[tail_ptr] <= in_entry;
   end

   // Register-file write port: one registered write per retired instruction
   always_ff @(posedge clock) begin
      if (reset || !retire) begin
         rd_we   <= 1'b0;
         rd_data <= '0;
         rd_addr <= '0;
      end else begin
         rd_we   <= head_entry.we;
         rd_data <= head_entry.data;
         rd_addr <= head_entry.rd;
      end
   end

   // A non-one-hot source select on an accepted instruction is illegal
   always_ff @(posedge clock) begin
      if (!reset && lsu_valid && lsu_ready) assert ($onehot0(wb_sel));
   end

endmodule

// File: tb/tb_ysyx_24080006_wbu_q.sv
// tb/tb_ysyx_24080006_wbu_q.sv - randomized model-checked bench for the writeback queue
module tb_ysyx_24080006_wbu_q;

   localparam int DEPTH = 2;

   logic        clock;
   logic        reset;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [31:0] alu_result;
   logic [31:0] mem_rdata;
   logic [31:0] csr_rdata;
   logic [31:0] pc;
   logic [3:0]  wb_sel;
   logic [2:0]  ld_fmt;
   logic [1:0]  addr_lo;
   logic [3:0]  rd;
   logic        ifu_valid;
   logic        ifu_ready;
   logic [31:0] rd_data;
   logic [3:0]  rd_addr;
   logic        rd_we;

   ysyx_24080006_wbu_q #(.XLEN(32), .REG_AW(4), .DEPTH(DEPTH)) dut (
      .clock      (clock),
      .reset      (reset),
      .lsu_valid  (lsu_valid),
      .lsu_ready  (lsu_ready),
      .alu_result (alu_result),
      .mem_rdata  (mem_rdata),
      .csr_rdata  (csr_rdata),
      .pc         (pc),
      .wb_sel     (wb_sel),
      .ld_fmt     (ld_fmt),
      .addr_lo    (addr_lo),
      .rd         (rd),
      .ifu_valid  (ifu_valid),
      .ifu_ready  (ifu_ready),
      .rd_data    (rd_data),
      .rd_addr    (rd_addr),
      .rd_we      (rd_we)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        we;
      logic [3:0]  addr;
      logic [31:0] data;
   } ent_t;

   ent_t        model_q[$];
   ent_t        wlog[$];
   logic        exp_we;
   logic [3:0]  exp_addr;
   logic [31:0] exp_data;
   logic        checking;
   logic        prev_ret;
   int          n_pass;
   int          n_total;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] m, input logic [1:0] a, input logic [2:0] f);
      logic [31:0] b;
      logic [31:0] h;
      b = (m >> (a * 8)) & 32'hFF;
      h = a[1] ? (m >> 16) : (m & 32'hFFFF);
      case (f)
         3'b000:  return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
         3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
         3'b100:  return b;
         3'b101:  return h;
         default: return m;
      endcase
   endfunction

   function automatic ent_t make_entry();
      ent_t e;
      case (wb_sel)
         4'b0001: e.data = alu_result;
         4'b0010: e.data = model_load(mem_rdata, addr_lo, ld_fmt);
         4'b0100: e.data = csr_rdata;
         4'b1000: e.data = pc + 32'd4;
         default: e.data = 32'd0;
      endcase
      e.addr = rd;
      e.we   = (wb_sel != 0) && (rd != 0);
      return e;
   endfunction

   // One clock of stimulus: compare at negedge, advance the model at posedge
   task automatic step(output logic acc);
      logic e_iv, e_lr, ret, psh, byp;
      ent_t inc, head;
      @(negedge clock);
      inc = make_entry();
      byp = 1'b0;
`ifdef YSYX_24080006_WBU_BYPASS_EN
      byp = (model_q.size() == 0) && lsu_valid;
`endif
      e_iv = !reset && (model_q.size() != 0 || byp);
      ret  = e_iv && ifu_ready;
      e_lr = !reset && (model_q.size() < DEPTH || ret);
      psh  = lsu_valid && e_lr && !(byp && ret);
      head = (model_q.size() != 0) ? model_q[0] : inc;
      if (checking) begin
         check("ifu_valid", 32'(ifu_valid), 32'(e_iv));
         check("lsu_ready", 32'(lsu_ready), 32'(e_lr));
         check("rd_we", 32'(rd_we), 32'(exp_we));
         check("rd_addr", 32'(rd_addr), 32'(exp_addr));
         check("rd_data", rd_data, exp_data);
      end
      if (prev_ret) wlog.push_back('{rd_we, rd_addr, rd_data});
      prev_ret = ifu_valid && ifu_ready;
      acc = psh;
      @(posedge clock);
      if (reset) begin
         model_q.delete();
         exp_we = 0; exp_addr = 0; exp_data = 0;
         checking = 1'b1;
      end else begin
         if (ret) begin
            exp_we = head.we; exp_addr = head.addr; exp_data = head.data;
            if (model_q.size() != 0) void'(model_q.pop_front());
         end else begin
            exp_we = 0; exp_addr = 0; exp_data = 0;
         end
         if (psh) model_q.push_back(inc);
      end
      #1;
   endtask

   task automatic set_in(input logic [3:0] sel, input logic [31:0] val, input logic [3:0] r);
      lsu_valid = 1'b1; wb_sel = sel; rd = r;
      alu_result = val; csr_rdata = val; pc = val; mem_rdata = val;
   endtask

   task automatic check_log(input int idx, input logic we, input logic [3:0] a, input logic [31:0] d);
      if (idx >= wlog.size()) begin
         n_total++;
         $display("FAIL log_missing: got %0d entries expected more than %0d", wlog.size(), idx);
      end else begin
         check("log_we", 32'(wlog[idx].we), 32'(we));
         check("log_addr", 32'(wlog[idx].addr), 32'(a));
         check("log_data", wlog[idx].data, d);
      end
   endtask

   initial begin
      logic acc;
      logic [2:0] fmts [5];
      fmts[0] = 3'b000; fmts[1] = 3'b001; fmts[2] = 3'b010; fmts[3] = 3'b100; fmts[4] = 3'b101;
      n_pass = 0; n_total = 0; checking = 1'b0; prev_ret = 1'b0;
      exp_we = 0; exp_addr = 0; exp_data = 0;
      reset = 1'b1; lsu_valid = 0; ifu_ready = 0;
      alu_result = 0; mem_rdata = 0; csr_rdata = 0; pc = 0;
      wb_sel = 0; ld_fmt = 0; addr_lo = 0; rd = 0;
      step(acc); step(acc);
      reset = 1'b0;
      #1;
      check("reset_ifu_valid", 32'(ifu_valid), 32'd0);
      check("reset_lsu_ready", 32'(lsu_ready), 32'd1);
      check("reset_rd_we", 32'(rd_we), 32'd0);

      // ALU writeback
      wlog.delete();
      ifu_ready = 1'b1;
      set_in(4'b0001, 32'h1234_5678, 4'd5);
      step(acc);
      lsu_valid = 0;
      repeat (3) step(acc);
      check_log(0, 1'b1, 4'd5, 32'h1234_5678);

      // Load lane extraction and extension
      wlog.delete();
      for (int i = 0; i < 4; i++) begin
         set_in(4'b0010, 32'h80FF_7F01, 4'(i + 1));
         ld_fmt  = (i == 0 || i == 1) ? 3'b000 : (i == 2) ? 3'b101 : 3'b001;
         addr_lo = (i == 0) ? 2'd1 : 2'd2;
         for (int k = 0; k < 20; k++) begin
            step(acc);
            if (acc) break;
         end
      end
      lsu_valid = 0;
      repeat (4) step(acc);
      check_log(0, 1'b1, 4'd1, 32'h0000_007F);
      check_log(1, 1'b1, 4'd2, 32'hFFFF_FFFF);
      check_log(2, 1'b1, 4'd3, 32'h0000_80FF);
      check_log(3, 1'b1, 4'd4, 32'hFFFF_80FF);

      // No-write retirements
      wlog.delete();
      ld_fmt = 3'b010; addr_lo = 0;
      set_in(4'b0001, 32'hDEAD_BEEF, 4'd0);
      step(acc);
      set_in(4'b0000, 32'hDEAD_BEEF, 4'd5);
      step(acc);
      lsu_valid = 0;
      repeat (3) step(acc);
      check("nowrite_retires", 32'(wlog.size()), 32'd2);
      check_log(0, 1'b0, 4'd0, 32'hDEAD_BEEF);
      check_log(1, 1'b0, 4'd5, 32'h0000_0000);

      // Backpressure with a full queue, then push+pop together
      wlog.delete();
      ifu_ready = 1'b0;
      for (int i = 1; i <= 2; i++) begin
         set_in(4'b0001, 32'(i), 4'(i));
         step(acc);
      end
      set_in(4'b0001, 32'd3, 4'd3);
      #1;
      check("full_lsu_ready", 32'(lsu_ready), 32'd0);
      step(acc);
      ifu_ready = 1'b1;
      #1;
      check("pushpop_lsu_ready", 32'(lsu_ready), 32'd1);
      step(acc);
      lsu_valid = 0;
      repeat (5) step(acc);
      check_log(0, 1'b1, 4'd1, 32'd1);
      check_log(1, 1'b1, 4'd2, 32'd2);
      check_log(2, 1'b1, 4'd3, 32'd3);

      // PC+4 including wrap
      wlog.delete();
      set_in(4'b1000, 32'hFFFF_FFFC, 4'd7);
      step(acc);
      set_in(4'b1000, 32'h8000_0000, 4'd8);
      step(acc);
      lsu_valid = 0;
      repeat (3) step(acc);
      check_log(0, 1'b1, 4'd7, 32'h0000_0000);
      check_log(1, 1'b1, 4'd8, 32'h8000_0004);

      // Reset with queued entries drops them
      wlog.delete();
      prev_ret = 1'b0;
      ifu_ready = 1'b0;
      set_in(4'b0001, 32'hAAAA_0001, 4'd9);
      step(acc);
      set_in(4'b0001, 32'hAAAA_0002, 4'd10);
      step(acc);
      lsu_valid = 0;
      reset = 1'b1;
      step(acc);
      reset = 1'b0;
      #1;
      check("post_reset_ifu_valid", 32'(ifu_valid), 32'd0);
      check("post_reset_rd_we", 32'(rd_we), 32'd0);
      ifu_ready = 1'b1;
      repeat (3) step(acc);
      check("dropped_no_retire", 32'(wlog.size()), 32'd0);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         reset      = ($urandom_range(0, 199) == 0);
         lsu_valid  = ($urandom_range(0, 99) < 60);
         ifu_ready  = ($urandom_range(0, 99) < 55);
         alu_result = $urandom;
         mem_rdata  = $urandom;
         csr_rdata  = $urandom;
         pc         = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
         case ($urandom_range(0, 4))
            0: wb_sel = 4'b0000;
            1: wb_sel = 4'b0001;
            2: wb_sel = 4'b0010;
            3: wb_sel = 4'b0100;
            default: wb_sel = 4'b1000;
         endcase
         ld_fmt  = fmts[$urandom_range(0, 4)];
         addr_lo = 2'($urandom_range(0, 3));
         rd      = 4'($urandom_range(0, 15));
         step(acc);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
